// File: rtl/fxp_pkg.sv
// Shared fixed-point package: FSM state encoding, default word geometry and
// counter-width helper used by the fixed-point arithmetic blocks.
package fxp_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } fxp_state_t;

  localparam int FXP_N_DEF = 32;
  localparam int FXP_Q_DEF = 15;

  // Bit counter must hold N+Q-2, the index of the first quotient bit.
  function automatic int cnt_width(input int n, input int q);
    return $clog2(n + q);
  endfunction

endpackage

// File: rtl/fxp_div.sv
// Sign-magnitude Q-format divider: restoring division, one quotient bit per
// cycle MSB first, with divide-by-zero and overflow saturation.
//
// Handshake: an operand pair transfers on a rising edge where in_valid and
// in_ready are both high; a result transfers on a rising edge where out_valid
// and out_ready are both high. out_valid, quotient and flags hold until then.
module fxp_div
  import fxp_pkg::*;
#(
  parameter int N = FXP_N_DEF,
  parameter int Q = FXP_Q_DEF
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] dividend,
  input  logic [N-1:0] divisor,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] quotient,
  output logic         div_by_zero,
  output logic         overflow,
  output logic [1:0]   dbg_state
);

  localparam int MW = N - 1;        // magnitude width
  localparam int NW = MW + Q;       // numerator / raw quotient width
  localparam int DW = NW + MW - 1;  // divisor aligned to the top quotient bit
  localparam int CW = cnt_width(N, Q);

  fxp_state_t     r_state;
  logic [CW-1:0]  r_cnt;
  logic [NW-1:0]  r_rem;
  logic [NW-1:0]  r_quo;
  logic [DW-1:0]  r_dalign;
  logic           r_sign;
  logic           r_in_ready;
  logic           r_out_valid;
  logic [N-1:0]   r_quotient;
  logic           r_dbz;
  logic           r_ovf;

  logic [MW-1:0]  w_dvd_mag;
  logic [MW-1:0]  w_dvs_mag;
  logic           w_sign;
  logic           w_ge;
  logic [NW-1:0]  w_rem_sub;
  logic [NW-1:0]  w_quo_fin;
  logic           w_ovf_fin;
  logic [MW-1:0]  w_mag_fin;

  assign w_dvd_mag = dividend[N-2:0];
  assign w_dvs_mag = divisor[N-2:0];
  assign w_sign    = dividend[N-1] ^ divisor[N-1];

  // A set ge means the aligned divisor fits, so its bits above NW are zero.
  assign w_ge      = {{(DW-NW){1'b0}}, r_rem} >= r_dalign;
  assign w_rem_sub = r_rem - r_dalign[NW-1:0];
  assign w_quo_fin = r_quo | {{(NW-1){1'b0}}, w_ge};
  assign w_ovf_fin = |w_quo_fin[NW-1:MW];
  assign w_mag_fin = w_ovf_fin ? {MW{1'b1}} : w_quo_fin[MW-1:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_cnt       <= '0;
      r_rem       <= '0;
      r_quo       <= '0;
      r_dalign    <= '0;
      r_sign      <= 1'b0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_quotient  <= '0;
      r_dbz       <= 1'b0;
      r_ovf       <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (in_valid) begin
            r_sign     <= w_sign;
            r_in_ready <= 1'b0;
            if (w_dvs_mag == '0) begin
              r_state     <= DONE;
              r_out_valid <= 1'b1;
              r_quotient  <= {w_sign, {MW{1'b1}}};
              r_dbz       <= 1'b1;
              r_ovf       <= 1'b0;
            end else begin
              r_state  <= CALC;
              r_cnt    <= CW'(N + Q - 2);
              r_rem    <= {w_dvd_mag, {Q{1'b0}}};
              r_dalign <= DW'(w_dvs_mag) << (NW - 1);
              r_quo    <= '0;
            end
          end
        end
        CALC: begin
          if (w_ge) begin
            r_rem <= w_rem_sub;
            r_quo <= r_quo | (NW'(1) << r_cnt);
          end
          r_dalign <= r_dalign >> 1;
          if (r_cnt == '0) begin
            r_state     <= DONE;
            r_out_valid <= 1'b1;
            r_quotient  <= {r_sign & (|w_mag_fin), w_mag_fin};
            r_dbz       <= 1'b0;
            r_ovf       <= w_ovf_fin;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        DONE: begin
          if (out_ready) begin
            r_state     <= IDLE;
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
          end
        end
        default: begin
          r_state     <= IDLE;
          r_out_valid <= 1'b0;
          r_in_ready  <= 1'b1;
        end
      endcase
    end
  end

  assign in_ready    = r_in_ready;
  assign out_valid   = r_out_valid;
  assign quotient    = r_quotient;
  assign div_by_zero = r_dbz;
  assign overflow    = r_ovf;
  assign dbg_state   = r_state;

endmodule

// File: tb/tb_fxp_div.sv
// Self-checking bench for fxp_div: directed and random operand pairs, random
// output backpressure, scoreboard with an arithmetic reference model.
module tb_fxp_div;

  localparam int N   = 32;
  localparam int Q   = 15;
  localparam int LAT = N + Q - 1;

  logic         clk = 1'b0;
  logic         rst_n = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [N-1:0] dividend = '0;
  logic [N-1:0] divisor = '0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [N-1:0] quotient;
  logic         div_by_zero;
  logic         overflow;
  logic [1:0]   dbg_state;

  typedef struct {
    logic [N-1:0] q;
    logic         dbz;
    logic         ovf;
    int           lat;
    int           acc;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  bit   hold_low = 1'b0;
  bit   prev_ov = 1'b0;

  fxp_div #(.N(N), .Q(Q)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .dividend(dividend), .divisor(divisor),
    .out_valid(out_valid), .out_ready(out_ready),
    .quotient(quotient), .div_by_zero(div_by_zero), .overflow(overflow),
    .dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic exp_t model(input logic [N-1:0] a, input logic [N-1:0] b);
    exp_t e;
    longint unsigned ma, mb, qq;
    logic s;
    ma = longint'(a[N-2:0]);
    mb = longint'(b[N-2:0]);
    s  = a[N-1] ^ b[N-1];
    e.acc = 0;
    e.ovf = 1'b0;
    e.dbz = 1'b0;
    if (mb == 0) begin
      e.q   = {s, {(N-1){1'b1}}};
      e.dbz = 1'b1;
      e.lat = 0;   // visible right after the accepting edge
    end else begin
      qq    = (ma << Q) / mb;
      e.lat = LAT;
      if (qq > ((64'd1 << (N-1)) - 1)) begin
        e.q   = {s, {(N-1){1'b1}}};
        e.ovf = 1'b1;
      end else begin
        e.q = {s && (qq != 0), qq[N-2:0]};
      end
    end
    return e;
  endfunction

  // ---------------- drivers ----------------
  task automatic issue(input logic [N-1:0] a, input logic [N-1:0] b);
    exp_t e;
    int w = 0;
    @(negedge clk);
    while (!in_ready && w < 500) begin
      @(negedge clk);
      w++;
    end
    if (!in_ready) begin
      chk("in_ready_timeout", 64'(in_ready), 64'd1);
      return;
    end
    in_valid = 1'b1;
    dividend = a;
    divisor  = b;
    @(posedge clk);
    #1;
    e = model(a, b);
    e.acc = cyc;
    exp_q.push_back(e);
    in_valid = 1'b0;
    dividend = $urandom;
    divisor  = $urandom;
  endtask

  task automatic drain();
    int w = 0;
    while (exp_q.size() > 0 && w < 3000) begin
      @(negedge clk);
      w++;
    end
    chk("drain_timeout", 64'(exp_q.size()), 64'd0);
  endtask

  initial begin
    forever begin
      @(posedge clk);
      #1;
      out_ready = hold_low ? 1'b0 : ($urandom_range(0, 3) != 0);
    end
  end

  // ---------------- monitor / scoreboard ----------------
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_ov = 1'b0;
    end else begin
      if (out_valid) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_result", 64'(out_valid), 64'd0);
        end else begin
          if (!prev_ov) chk("latency", 64'(cyc - exp_q[0].acc), 64'(exp_q[0].lat));
          chk("quotient", 64'(quotient), 64'(exp_q[0].q));
          chk("div_by_zero", 64'(div_by_zero), 64'(exp_q[0].dbz));
          chk("overflow", 64'(overflow), 64'(exp_q[0].ovf));
          chk("in_ready_busy", 64'(in_ready), 64'd0);
          if (out_ready) void'(exp_q.pop_front());
        end
      end
      prev_ov = out_valid;
    end
  end

  // ---------------- main sequence ----------------
  initial begin
    logic [N-1:0] a, b;
    exp_t e;
    bit saw;
    int w;

    #2 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_quotient", 64'(quotient), 64'd0);
    chk("rst_dbz", 64'(div_by_zero), 64'd0);
    chk("rst_ovf", 64'(overflow), 64'd0);
    chk("rst_state", 64'(dbg_state), 64'd0);
    rst_n = 1'b1;

    issue(32'h0001_8000, 32'h0001_0000);
    issue(32'h8000_8000, 32'h0000_4000);
    issue(32'h0000_8000, 32'h8000_0000);
    issue(32'h4000_0000, 32'h0000_0001);
    issue(32'h8000_0000, 32'h0000_8000);
    drain();

    // Backpressure: result must hold for 10 cycles with out_ready low.
    hold_low = 1'b1;
    issue(32'h0001_8000, 32'h0001_0000);
    w = 0;
    while (!out_valid && w < 100) begin
      @(negedge clk);
      w++;
    end
    repeat (10) @(negedge clk);
    chk("hold_out_valid", 64'(out_valid), 64'd1);
    chk("hold_in_ready", 64'(in_ready), 64'd0);
    hold_low = 1'b0;
    drain();

    repeat (40) begin
      a = {1'($urandom), 31'($urandom) >> $urandom_range(0, 30)};
      case ($urandom_range(0, 9))
        0:       b = {1'($urandom), 31'd0};
        1, 2, 3: b = {1'($urandom), 31'($urandom_range(1, 255))};
        default: b = {1'($urandom), 31'($urandom) >> $urandom_range(0, 30)};
      endcase
      issue(a, b);
    end
    drain();

    // Reset 20 cycles into a calculation discards it.
    issue(32'h0001_8000, 32'h0001_0000);
    repeat (20) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("midreset_in_ready", 64'(in_ready), 64'd1);
    chk("midreset_out_valid", 64'(out_valid), 64'd0);
    chk("midreset_quotient", 64'(quotient), 64'd0);
    exp_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    saw = 1'b0;
    repeat (60) begin
      @(negedge clk);
      if (out_valid) saw = 1'b1;
    end
    chk("no_result_after_reset", 64'(saw), 64'd0);

    // First edge after reset release accepts an operand pair.
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    in_valid = 1'b1;
    dividend = 32'h8000_8000;
    divisor  = 32'h0000_4000;
    #2 rst_n = 1'b1;
    @(posedge clk);
    #1;
    e = model(32'h8000_8000, 32'h0000_4000);
    e.acc = cyc;
    exp_q.push_back(e);
    in_valid = 1'b0;
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
